// File: rtl/vote_session_ctrl.sv
// vote_session_ctrl: collects four station ballots over valid/ack, drives the voter and latches its result.
// Optional session timeout is enabled by defining VOTE_TIMEOUT_EN.
module vote_session_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TIMER_W        = $clog2(TIMEOUT_CYCLES)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       clear,
    input  logic [3:0] vote_valid,
    input  logic [3:0] vote_val,
    output logic [3:0] vote_ack,
    output logic [3:0] voter_i,
    input  logic [2:0] voter_o,
    output logic [2:0] result,
    output logic       result_valid,
    output logic [3:0] voted_mask,
    output logic       busy,
    output logic       timed_out,
    output logic       dup_seen
);
    typedef enum logic [1:0] {IDLE, OPEN, EVAL, DONE} state_t;

    state_t     state_q, state_d;
    logic [3:0] ballot_q, ballot_d, mask_q, mask_d, ack_q, ack_d;
    logic [2:0] result_q, result_d;
    logic       rv_q, rv_d, to_q, to_d, dup_q, dup_d;
    logic [3:0] accept, mask_nxt;
    logic       expire, open_start;

    assign open_start = state_q == IDLE && start && !clear;
    assign accept     = (state_q == OPEN) ? vote_valid & ~mask_q : 4'b0000;
    assign mask_nxt   = mask_q | accept;

`ifdef VOTE_TIMEOUT_EN
    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    logic [TIMER_W-1:0] timer_q, timer_d;

    assign expire = state_q == OPEN && timer_q == LAST;

    // Timer is held at zero in IDLE so every session starts from a fresh count.
    always_comb begin
        timer_d = (state_q == IDLE) ? '0 :
                  (state_q == OPEN && timer_q != LAST) ? timer_q + 1'b1 : timer_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) timer_q <= '0;
        else        timer_q <= timer_d;
    end
`else
    logic unused_timeout_cfg;

    assign expire             = 1'b0;
    assign unused_timeout_cfg = ^TIMER_W'(TIMEOUT_CYCLES - 1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear) state_d = IDLE;
        else begin
            case (state_q)
                IDLE:    state_d = start ? OPEN : IDLE;
                OPEN:    state_d = (mask_nxt == 4'hF || expire) ? EVAL : OPEN;
                EVAL:    state_d = DONE;
                default: state_d = DONE;
            endcase
        end
    end

    always_comb begin
        busy    = state_q == OPEN || state_q == EVAL;
        voter_i = (state_q == EVAL || state_q == DONE) ? ballot_q : 4'b0000;
    end

    // clear outranks everything, so a vote arriving with clear is neither acked nor stored.
    always_comb begin
        ack_d    = clear ? 4'b0000 : accept;
        mask_d   = (clear || open_start) ? 4'b0000 : mask_nxt;
        ballot_d = open_start ? 4'b0000 :
                   clear ? ballot_q : (ballot_q & ~accept) | (vote_val & accept);
        dup_d    = (clear || open_start) ? 1'b0 :
                   dup_q | (state_q == OPEN && |(vote_valid & mask_q));
        to_d     = (clear || open_start) ? 1'b0 : to_q | (expire && mask_nxt != 4'hF);
        result_d = clear ? 3'b000 : (state_q == EVAL) ? voter_o : result_q;
        rv_d     = clear ? 1'b0 : rv_q | (state_q == EVAL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ballot_q <= 4'b0000;
            mask_q   <= 4'b0000;
            ack_q    <= 4'b0000;
            result_q <= 3'b000;
            rv_q     <= 1'b0;
            to_q     <= 1'b0;
            dup_q    <= 1'b0;
        end else begin
            ballot_q <= ballot_d;
            mask_q   <= mask_d;
            ack_q    <= ack_d;
            result_q <= result_d;
            rv_q     <= rv_d;
            to_q     <= to_d;
            dup_q    <= dup_d;
        end
    end

    assign vote_ack     = ack_q;
    assign voted_mask   = mask_q;
    assign result       = result_q;
    assign result_valid = rv_q;
    assign timed_out    = to_q;
    assign dup_seen     = dup_q;
endmodule

// File: tb/tb_vote_session_ctrl.sv
// tb_vote_session_ctrl: table vectors, corner-case sequences and random traffic checked
// against a ballot-box reference model; honours VOTE_TIMEOUT_EN like the design.
module tb_vote_session_ctrl;
    localparam int TC = 16;
`ifdef VOTE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, clear = 1'b0;
    logic [3:0] vote_valid = 4'b0, vote_val = 4'b0;
    logic [3:0] vote_ack, voter_i, voted_mask;
    logic [2:0] voter_o, result;
    logic       result_valid, busy, timed_out, dup_seen;

    int total = 0, bad = 0;

    vote_session_ctrl #(.TIMEOUT_CYCLES(TC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .vote_valid(vote_valid), .vote_val(vote_val), .vote_ack(vote_ack),
        .voter_i(voter_i), .voter_o(voter_o), .result(result),
        .result_valid(result_valid), .voted_mask(voted_mask), .busy(busy),
        .timed_out(timed_out), .dup_seen(dup_seen)
    );

    always #5 clk = ~clk;

    // Voter stand-in: counts yes-votes.
    assign voter_o = 3'($countones(voter_i));

    // Reference model: a ballot box with a phase number (0 idle, 1 open, 2 eval, 3 done).
    int   ph = 0, n_open = 0;
    bit   voted[4], bal[4];
    bit   m_to = 0, m_dup = 0, m_rv = 0;
    int   m_res = 0;
    logic [3:0] m_ack = 4'b0;

    function automatic logic [3:0] pack(input bit a[4]);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = a[i];
        return v;
    endfunction

    task automatic model_reset();
        ph = 0; m_to = 0; m_dup = 0; m_rv = 0; m_res = 0; m_ack = 4'b0;
        for (int i = 0; i < 4; i++) begin voted[i] = 0; bal[i] = 0; end
    endtask

    task automatic model_edge(input bit st, input bit cl, input logic [3:0] vv, input logic [3:0] vl);
        int n;
        m_ack = 4'b0;
        if (cl) begin
            ph = 0; m_res = 0; m_rv = 0; m_to = 0; m_dup = 0;
            for (int i = 0; i < 4; i++) voted[i] = 0;
        end else if (ph == 0) begin
            if (st) begin
                ph = 1; n_open = 0; m_to = 0; m_dup = 0;
                for (int i = 0; i < 4; i++) begin voted[i] = 0; bal[i] = 0; end
            end
        end else if (ph == 1) begin
            n = 0;
            for (int i = 0; i < 4; i++) begin
                if (vv[i] && voted[i]) m_dup = 1;
                else if (vv[i]) begin voted[i] = 1; bal[i] = vl[i]; m_ack[i] = 1'b1; end
                n += int'(voted[i]);
            end
            if (n == 4) ph = 2;
            else if (TO_EN && n_open == TC - 1) begin ph = 2; m_to = 1; end
            n_open++;
        end else if (ph == 2) begin
            m_res = 0;
            for (int i = 0; i < 4; i++) m_res += int'(bal[i]);
            m_rv = 1; ph = 3;
        end
    endtask

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, " ack"}, int'(vote_ack), int'(m_ack));
        check({tag, " voter_i"}, int'(voter_i), (ph >= 2) ? int'(pack(bal)) : 0);
        check({tag, " result"}, int'(result), m_res);
        check({tag, " result_valid"}, int'(result_valid), int'(m_rv));
        check({tag, " mask"}, int'(voted_mask), int'(pack(voted)));
        check({tag, " busy"}, int'(busy), int'(ph == 1 || ph == 2));
        check({tag, " timed_out"}, int'(timed_out), int'(m_to));
        check({tag, " dup_seen"}, int'(dup_seen), int'(m_dup));
    endtask

    task automatic step(input bit st, input bit cl, input logic [3:0] vv, input logic [3:0] vl, input string tag);
        @(negedge clk);
        start = st; clear = cl; vote_valid = vv; vote_val = vl;
        @(posedge clk);
        model_edge(st, cl, vv, vl);
        #1;
        compare_all(tag);
    endtask

    typedef struct {
        bit st, cl;
        logic [3:0] vv, vl, ack, vi, mask;
        bit busy, rv;
        logic [2:0] res;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{st:1, cl:0, vv:4'h0, vl:4'h0, ack:4'h0, vi:4'h0, mask:4'h0, busy:1, rv:0, res:3'd0};
        tbl[1] = '{st:0, cl:0, vv:4'hF, vl:4'hB, ack:4'hF, vi:4'hB, mask:4'hF, busy:1, rv:0, res:3'd0};
        tbl[2] = '{st:0, cl:0, vv:4'h0, vl:4'h0, ack:4'h0, vi:4'hB, mask:4'hF, busy:0, rv:1, res:3'd3};
        tbl[3] = '{st:1, cl:0, vv:4'h0, vl:4'h0, ack:4'h0, vi:4'hB, mask:4'hF, busy:0, rv:1, res:3'd3};
        tbl[4] = '{st:0, cl:1, vv:4'h0, vl:4'h0, ack:4'h0, vi:4'h0, mask:4'h0, busy:0, rv:0, res:3'd0};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset ack", int'(vote_ack), 0);
        check("reset voter_i", int'(voter_i), 0);
        check("reset result_valid", int'(result_valid), 0);
        check("reset busy", int'(busy), 0);
        check("reset mask", int'(voted_mask), 0);
        check("reset timed_out", int'(timed_out), 0);
        check("reset dup_seen", int'(dup_seen), 0);
        @(negedge clk) rst_n = 1'b1;

        for (int r = 0; r < 5; r++) begin
            step(tbl[r].st, tbl[r].cl, tbl[r].vv, tbl[r].vl, "tbl");
            check("tbl ack", int'(vote_ack), int'(tbl[r].ack));
            check("tbl voter_i", int'(voter_i), int'(tbl[r].vi));
            check("tbl mask", int'(voted_mask), int'(tbl[r].mask));
            check("tbl busy", int'(busy), int'(tbl[r].busy));
            check("tbl result_valid", int'(result_valid), int'(tbl[r].rv));
            check("tbl result", int'(result), int'(tbl[r].res));
        end

        // One station per cycle, station 1 re-requests with a different value.
        step(1, 0, 4'b0000, 4'b0000, "seq");
        step(0, 0, 4'b0001, 4'b0001, "seq");
        check("seq ack0", int'(vote_ack), 1);
        step(0, 0, 4'b0010, 4'b0010, "seq");
        check("seq ack1", int'(vote_ack), 2);
        step(0, 0, 4'b0110, 4'b0000, "seq");
        check("seq ack2 only", int'(vote_ack), 4);
        check("seq dup", int'(dup_seen), 1);
        step(0, 0, 4'b1000, 4'b1000, "seq");
        check("seq ack3", int'(vote_ack), 8);
        check("seq ballot kept", int'(voter_i), 4'b1011);
        step(0, 0, 4'b0000, 4'b0000, "seq");
        check("seq result", int'(result), 3);
        step(0, 1, 4'b0000, 4'b0000, "seq");

        // Clear in OPEN with a vote arriving on the same edge.
        step(1, 0, 4'b0000, 4'b0000, "clr");
        step(0, 0, 4'b0011, 4'b0011, "clr");
        step(0, 1, 4'b0100, 4'b0100, "clr");
        check("clr no ack", int'(vote_ack), 0);
        check("clr mask", int'(voted_mask), 0);
        check("clr busy", int'(busy), 0);
        step(1, 0, 4'b0000, 4'b0000, "clr");
        check("clr reopen", int'(busy), 1);
        check("clr fresh mask", int'(voted_mask), 0);
        step(0, 0, 4'b1111, 4'b0110, "clr");
        step(0, 0, 4'b0000, 4'b0000, "clr");
        check("clr result", int'(result), 2);
        step(0, 1, 4'b0000, 4'b0000, "clr");

        // Asynchronous reset while in EVAL.
        step(1, 0, 4'b0000, 4'b0000, "rst");
        step(0, 0, 4'b1111, 4'b1111, "rst");
        check("rst in eval", int'(voter_i), 15);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst async voter_i", int'(voter_i), 0);
        check("rst async busy", int'(busy), 0);
        check("rst async mask", int'(voted_mask), 0);
        check("rst async ack", int'(vote_ack), 0);
        @(posedge clk);
        #1;
        check("rst no result_valid", int'(result_valid), 0);
        @(negedge clk) rst_n = 1'b1;

        if (TO_EN) begin
            step(1, 0, 4'b0000, 4'b0000, "to");
            step(0, 0, 4'b0101, 4'b0101, "to");
            for (int k = 2; k < TC; k++) step(0, 0, 4'b0000, 4'b0000, "to");
            check("to still open", int'(busy && voter_i == 4'b0000), 1);
            step(0, 0, 4'b0000, 4'b0000, "to");
            check("to eval voter_i", int'(voter_i), 4'b0101);
            check("to timed_out", int'(timed_out), 1);
            check("to mask", int'(voted_mask), 4'b0101);
        end else begin
            step(1, 0, 4'b0000, 4'b0000, "noto");
            step(0, 0, 4'b0111, 4'b0101, "noto");
            for (int k = 0; k < 1000; k++) step(0, 0, 4'b0000, 4'b0000, "noto");
            check("noto busy", int'(busy), 1);
            check("noto timed_out", int'(timed_out), 0);
            check("noto voter_i", int'(voter_i), 0);
            step(0, 0, 4'b1000, 4'b1000, "noto");
            check("noto eval", int'(voter_i), 4'b1101);
            step(0, 0, 4'b0000, 4'b0000, "noto");
            check("noto result_valid", int'(result_valid), 1);
        end
        step(0, 1, 4'b0000, 4'b0000, "to");

        for (int k = 0; k < 800; k++)
            step($urandom_range(3) == 0, $urandom_range(24) == 0,
                 4'($urandom_range(15)) & 4'($urandom_range(15)), 4'($urandom_range(15)), "rnd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
